// File: rtl/digital_tube_avalon_master.sv
// Converts a binary value to six BCD digits with sequential double-dabble and
// writes the result (plus a one-time display-enable) to a 7-segment slave over Avalon-MM.
module digital_tube_avalon_master #(
  parameter int VALUE_W     = 20,
  parameter bit AUTO_ENABLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               chipselect,
  output logic               write_n,
  output logic [1:0]         address,
  output logic [31:0]        writedata,
  input  logic               waitrequest
);

  typedef enum logic [2:0] {IDLE, CONV, WR_DATA, WR_EN, DONE} state_t;

  localparam int CNT_W = $clog2(VALUE_W);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [23:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               big_q, big_d;
  logic               overflow_q, overflow_d;
  logic               enabled_q, enabled_d;
  logic [23:0]        bcd_adj;
  logic [31:0]        value_ext;

  assign value_ext = 32'(value);

  // Add-3 correction on every digit >= 5, ahead of this cycle's shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    big_d      = big_q;
    overflow_d = overflow_q;
    enabled_d  = enabled_q;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'b00;
    writedata  = 32'h0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = value;
          bcd_d      = 24'h0;
          cnt_d      = CNT_W'(VALUE_W - 1);
          big_d      = value_ext > 32'd999999;
          overflow_d = overflow_q | big_d;
          state_d    = CONV;
        end
      end
      CONV: begin
        bcd_d   = {bcd_adj[22:0], shift_q[VALUE_W-1]};
        shift_d = {shift_q[VALUE_W-2:0], 1'b0};
        if (cnt_q == '0) state_d = WR_DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_DATA: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = {8'h00, big_q ? 24'h999999 : bcd_q};
        if (!waitrequest) begin
          state_d = (AUTO_ENABLE && !enabled_q) ? WR_EN : DONE;
        end
      end
      WR_EN: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'b01;
        writedata  = 32'h0000_0001;
        if (!waitrequest) begin
          enabled_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      big_q      <= 1'b0;
      overflow_q <= 1'b0;
      enabled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      big_q      <= big_d;
      overflow_q <= overflow_d;
      enabled_q  <= enabled_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_digital_tube_avalon_master.sv
// Directed bench for digital_tube_avalon_master: a negedge bus monitor logs every
// accepted write and done pulse with the rising edge it belongs to.
module tb_digital_tube_avalon_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] value = '0;
  logic        busy, done, overflow, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic        waitrequest = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int hold_req = 0;

  int          acc_total = 0;
  logic [1:0]  acc_addr_q[$];
  logic [31:0] acc_data_q[$];
  int          acc_edge_q[$];
  int          done_total = 0;
  int          done_edge = 0;
  int          stable_viol = 0;
  int          data_run = 0;
  int          last_data_cycles = 0;
  logic        prev_waiting = 1'b0;
  logic [33:0] prev_bus = '0;

  digital_tube_avalon_master #(.VALUE_W(20), .AUTO_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .overflow(overflow),
    .chipselect(chipselect), .write_n(write_n), .address(address),
    .writedata(writedata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Slave model: stalls the data write for hold_req cycles; anything seen here
  // is committed on the next rising edge, hence edge_cnt + 1.
  always @(negedge clk) begin
    if (!rst && chipselect && !write_n) begin
      if (address == 2'b00) begin
        waitrequest = (data_run < hold_req);
        data_run++;
      end else begin
        waitrequest = 1'b0;
      end
      if (prev_waiting && {address, writedata} !== prev_bus) stable_viol++;
      prev_waiting = waitrequest;
      prev_bus = {address, writedata};
      if (!waitrequest) begin
        if (address == 2'b00) last_data_cycles = data_run;
        acc_addr_q.push_back(address);
        acc_data_q.push_back(writedata);
        acc_edge_q.push_back(edge_cnt + 1);
        acc_total++;
        data_run = 0;
      end
    end else begin
      waitrequest = 1'b0;
      prev_waiting = 1'b0;
      data_run = 0;
    end
    if (done) begin
      done_total++;
      done_edge = edge_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one sampling edge; k is that edge.
  task automatic applyStimulus(input logic [19:0] v, input int hold, output int k,
                               output int acc_base, output int done_base);
    @(negedge clk);
    value = v;
    hold_req = hold;
    start = 1'b1;
    k = edge_cnt + 1;
    acc_base = acc_total;
    done_base = done_total;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic waitDone(input int done_base);
    int t = 0;
    while (done_total == done_base && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    checkOutput("done_pulse_count", 32'(done_total - done_base), 32'd1);
  endtask

  int k, ab, db;
  int stable_base;

  initial begin
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("rst_bus", {chipselect, write_n, 28'b0, address}, {1'b0, 1'b1, 28'b0, 2'b00});
    checkOutput("rst_wdata", writedata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First request: data write then one-time enable write.
    applyStimulus(20'd123456, 0, k, ab, db);
    waitDone(db);
    checkOutput("r1_acc_count", 32'(acc_total - ab), 32'd2);
    checkOutput("r1_data", acc_data_q[ab], 32'h0012_3456);
    checkOutput("r1_addr0", {30'b0, acc_addr_q[ab]}, 32'd0);
    checkOutput("r1_data_edge", 32'(acc_edge_q[ab] - k), 32'd21);
    checkOutput("r1_en_data", acc_data_q[ab+1], 32'h0000_0001);
    checkOutput("r1_en_addr", {30'b0, acc_addr_q[ab+1]}, 32'd1);
    checkOutput("r1_en_edge", 32'(acc_edge_q[ab+1] - k), 32'd22);
    checkOutput("r1_done_edge", 32'(done_edge - k), 32'd23);
    checkOutput("r1_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("r1_idle", {31'b0, busy}, 32'd0);

    applyStimulus(20'd999999, 0, k, ab, db);
    waitDone(db);
    checkOutput("r2_acc_count", 32'(acc_total - ab), 32'd1);
    checkOutput("r2_data", acc_data_q[ab], 32'h0099_9999);
    checkOutput("r2_addr", {30'b0, acc_addr_q[ab]}, 32'd0);
    checkOutput("r2_done_edge", 32'(done_edge - k), 32'd22);
    checkOutput("r2_overflow", {31'b0, overflow}, 32'd0);

    applyStimulus(20'd1000000, 0, k, ab, db);
    waitDone(db);
    checkOutput("r3_data", acc_data_q[ab], 32'h0099_9999);
    checkOutput("r3_overflow", {31'b0, overflow}, 32'd1);

    applyStimulus(20'd5, 0, k, ab, db);
    waitDone(db);
    checkOutput("r4_data", acc_data_q[ab], 32'h0000_0005);
    checkOutput("r4_overflow_sticky", {31'b0, overflow}, 32'd1);

    // Slave stalls the data write for three cycles.
    stable_base = stable_viol;
    applyStimulus(20'd42, 3, k, ab, db);
    waitDone(db);
    hold_req = 0;
    checkOutput("w_acc_count", 32'(acc_total - ab), 32'd1);
    checkOutput("w_data", acc_data_q[ab], 32'h0000_0042);
    checkOutput("w_cycles", 32'(last_data_cycles), 32'd4);
    checkOutput("w_stable", 32'(stable_viol - stable_base), 32'd0);
    checkOutput("w_acc_edge", 32'(acc_edge_q[ab] - k), 32'd24);
    checkOutput("w_done_edge", 32'(done_edge - k), 32'd25);

    // A start pulse during CONV must not disturb the captured value.
    applyStimulus(20'd31415, 0, k, ab, db);
    repeat (3) @(negedge clk);
    value = 20'd777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = 20'hABCDE;
    waitDone(db);
    checkOutput("ign_acc_count", 32'(acc_total - ab), 32'd1);
    checkOutput("ign_data", acc_data_q[ab], 32'h0003_1415);
    checkOutput("ign_done_edge", 32'(done_edge - k), 32'd22);

    // Reset in the middle of conversion aborts everything.
    applyStimulus(20'd654321, 0, k, ab, db);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_cs", {31'b0, chipselect}, 32'd0);
    checkOutput("abort_write_n", {31'b0, write_n}, 32'd1);
    checkOutput("abort_overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_write", 32'(acc_total - ab), 32'd0);
    checkOutput("abort_no_done", 32'(done_total - db), 32'd0);

    applyStimulus(20'd250, 0, k, ab, db);
    waitDone(db);
    checkOutput("re_acc_count", 32'(acc_total - ab), 32'd2);
    checkOutput("re_data", acc_data_q[ab], 32'h0000_0250);
    checkOutput("re_en_addr", {30'b0, acc_addr_q[ab+1]}, 32'd1);
    checkOutput("re_done_edge", 32'(done_edge - k), 32'd23);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digital_tube_avalon_master.md
DIGITAL_TUBE_AVALON_MASTER -- requirements
Module: digital_tube_avalon_master

Interface
REQ-001 SHALL have parameter VALUE_W, default 20, binary input width (2..20).
REQ-002 SHALL have parameter AUTO_ENABLE, default 1; when 1, the block writes the display-enable register after the first data write following reset.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port value  input  VALUE_W  unsigned binary number to display.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a request completes.
REQ-009 SHALL have port overflow  output  1  sticky flag: a request had value > 999999.
REQ-010 SHALL have port chipselect  output  1  Avalon-MM chip select, active-high.
REQ-011 SHALL have port write_n  output  1  Avalon-MM write strobe, active-low.
REQ-012 SHALL have port address  output  2  Avalon-MM word address (00 = data register, 01 = control register).
REQ-013 SHALL have port writedata  output  32  Avalon-MM write data.
REQ-014 SHALL have port waitrequest  input  1  Avalon-MM slave stall, active-high.

Function
REQ-015 SHALL implement FSM states: IDLE, CONV, WR_DATA, WR_EN, DONE.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture value into an internal register and enter CONV; start in any other state SHALL be ignored.
REQ-017 CONV SHALL perform sequential double-dabble: one source bit per cycle, MSB first, exactly VALUE_W cycles, into six 4-bit BCD digits.
REQ-018 The add-3 correction SHALL be applied to every digit >= 5 before each shift, within the same cycle.
REQ-019 If the captured value > 999999, the BCD result SHALL be forced to 0x999999 and overflow SHALL set; overflow SHALL clear only on reset.
REQ-020 After the last CONV cycle, the FSM SHALL enter WR_DATA.
REQ-021 In WR_DATA: chipselect=1, write_n=0, address=2'b00, writedata={8'h00, six BCD digits}, ordered most significant digit at bits 23:20 and least significant digit at bits 3:0.
REQ-022 A transfer SHALL be accepted on the rising edge where chipselect=1, write_n=0 and waitrequest=0.
REQ-023 Until acceptance, all Avalon outputs SHALL be held stable.
REQ-024 Exactly one acceptance SHALL occur per write state.
REQ-025 On acceptance in WR_DATA: if AUTO_ENABLE=1 and the enabled flag is 0, the FSM SHALL go to WR_EN; otherwise it SHALL go to DONE.
REQ-026 In WR_EN: address=2'b01, writedata=32'h00000001, with the same handshake as REQ-022 to REQ-024.
REQ-027 On acceptance in WR_EN, the enabled flag SHALL set and the FSM SHALL go to DONE.
REQ-028 The enabled flag SHALL clear only on reset.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 Outside WR_DATA and WR_EN: chipselect=0, write_n=1, address=2'b00, writedata=0.
REQ-031 Latency with waitrequest=0 SHALL be as follows, with start sampled at edge k:
- busy=1 from k;
- first write cycle k+VALUE_W+1;
- done at k+VALUE_W+2 (no enable write) or k+VALUE_W+3 (with enable write).
REQ-032 A new start SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-033 A value change during CONV or write states SHALL NOT affect the transfer in progress.

Reset
REQ-034 While rst=1, the outputs SHALL be:
- state=IDLE, busy=0, done=0, overflow=0, enabled flag=0;
- chipselect=0, write_n=1, address=0, writedata=0.
REQ-035 Reset asserted mid-CONV or mid-write SHALL abort immediately: the bus SHALL be released the same cycle, with no partial or deferred write and no done pulse after release.

Verification
REQ-036 Bench SHALL cover: first request after reset, value=123456, waitrequest=0 -> data write 0x00123456 at address 0 at k+21, enable write 0x00000001 at address 1 at k+22, done at k+23.
REQ-037 Bench SHALL cover: second request, value=999999 -> single write 0x00999999 at address 0, no address-1 write, done at k+22, overflow=0.
REQ-038 Bench SHALL cover: value=1000000 -> writedata 0x00999999, overflow=1 and still 1 after a later request with value=5 (writedata 0x00000005).
REQ-039 Bench SHALL cover: waitrequest held high 3 cycles in WR_DATA -> chipselect, write_n, address and writedata stable for 4 cycles, exactly one acceptance, done delayed 3 cycles.
REQ-040 Bench SHALL cover: start pulsed during CONV with a different value -> ignored; the original value is written.
REQ-041 Bench SHALL cover: rst asserted at CONV cycle 10 -> busy=0 and chipselect=0 immediately, no write and no done afterwards; the next request performs the enable write again.
